// File: rtl/stripe_issuer.sv
// Transmit end of the stripe tag-broadcast protocol: latches one job, hands
// the configuration to the stripe on request, then streams tag-stamped operand pairs.
module stripe_issuer #(
    parameter int data_width  = 16,
    parameter int block_width = 8 * data_width,
    parameter int tag_width   = 12,
    parameter int instr_width = 7,
    parameter int fifo_depth  = 4,
    parameter int gap_cycles  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [tag_width-1:0]   cmd_tagA,
    input  logic [tag_width-1:0]   cmd_tagB,
    input  logic [tag_width-1:0]   cmd_strideA,
    input  logic [tag_width-1:0]   cmd_strideB,
    input  logic [tag_width-1:0]   cmd_iter_lim,
    input  logic [instr_width-1:0] cmd_instr,
    input  logic                   opd_valid,
    output logic                   opd_ready,
    input  logic [block_width-1:0] opd_d0,
    input  logic [block_width-1:0] opd_d1,
    input  logic                   ext_req,
    output logic                   cfg_write,
    output logic [tag_width-1:0]   tagA_OUT,
    output logic [tag_width-1:0]   tagB_OUT,
    output logic [tag_width-1:0]   strideA_OUT,
    output logic [tag_width-1:0]   strideB_OUT,
    output logic [tag_width-1:0]   iter_lim_OUT,
    output logic [instr_width-1:0] instr_OUT,
    output logic                   bcast_valid,
    output logic [tag_width-1:0]   bcast_tag0,
    output logic [tag_width-1:0]   bcast_tag1,
    output logic [block_width-1:0] d0_OUT,
    output logic [block_width-1:0] d1_OUT,
    output logic                   busy,
    output logic                   done
);

    localparam int ptr_width = $clog2(fifo_depth);
    localparam logic [ptr_width:0] full_count = (ptr_width + 1)'(fifo_depth);
    localparam logic [1:0] gap_load = 2'(gap_cycles);

    typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DONE} state_t;

    state_t state, next_state;

    logic [block_width-1:0] fifo_d0 [fifo_depth];
    logic [block_width-1:0] fifo_d1 [fifo_depth];
    logic [ptr_width-1:0]   wr_ptr, rd_ptr;
    logic [ptr_width:0]     count;
    logic                   fifo_full, fifo_empty;

    logic [tag_width-1:0]   exp_a, exp_b, acc_cnt, beat_cnt;
    logic [1:0]             gap_cnt;
    logic [block_width-1:0] d0_hold, d1_hold;
    logic                   push, pop, cmd_fire;

    assign fifo_full  = (count == full_count);
    assign fifo_empty = (count == '0);
    assign cmd_fire   = cmd_valid & cmd_ready;
    assign push       = opd_valid & opd_ready;
    assign pop        = bcast_valid;

    assign bcast_tag0 = exp_a;
    assign bcast_tag1 = exp_b;
    assign d0_OUT     = bcast_valid ? fifo_d0[rd_ptr] : d0_hold;
    assign d1_OUT     = bcast_valid ? fifo_d1[rd_ptr] : d1_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // CONFIG leaves on the first ext_req, so a held request cannot re-strobe cfg_write.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_fire) next_state = CONFIG;
            CONFIG:  if (ext_req) next_state = (iter_lim_OUT == '0) ? DONE : STREAM;
            STREAM:  if (beat_cnt == iter_lim_OUT) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        opd_ready   = 1'b0;
        cfg_write   = 1'b0;
        bcast_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:   cmd_ready = !rst;
            CONFIG: begin
                busy      = 1'b1;
                cfg_write = ext_req;
            end
            STREAM: begin
                busy        = 1'b1;
                opd_ready   = !fifo_full && (acc_cnt < iter_lim_OUT);
                bcast_valid = !fifo_empty && (gap_cnt == 2'd0);
            end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagA_OUT     <= '0;
            tagB_OUT     <= '0;
            strideA_OUT  <= '0;
            strideB_OUT  <= '0;
            iter_lim_OUT <= '0;
            instr_OUT    <= '0;
        end else if (cmd_fire) begin
            tagA_OUT     <= cmd_tagA;
            tagB_OUT     <= cmd_tagB;
            strideA_OUT  <= cmd_strideA;
            strideB_OUT  <= cmd_strideB;
            iter_lim_OUT <= cmd_iter_lim;
            instr_OUT    <= cmd_instr;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d0[wr_ptr] <= opd_d0;
            fifo_d1[wr_ptr] <= opd_d1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            exp_a    <= '0;
            exp_b    <= '0;
            acc_cnt  <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            d0_hold  <= '0;
            d1_hold  <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                exp_a    <= exp_a + strideA_OUT;
                exp_b    <= exp_b + strideB_OUT;
                beat_cnt <= beat_cnt + 1'b1;
                gap_cnt  <= gap_load;
                d0_hold  <= fifo_d0[rd_ptr];
                d1_hold  <= fifo_d1[rd_ptr];
            end else if (gap_cnt != 2'd0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (cmd_fire) begin
                exp_a    <= cmd_tagA;
                exp_b    <= cmd_tagB;
                acc_cnt  <= '0;
                beat_cnt <= '0;
                gap_cnt  <= '0;
            end
        end
    end

endmodule
